// File: rtl/calc_param.sv
// calc_param: accumulator calculator with multi-cycle shifts and a circular undo history.
module calc_param #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [2:0]                 func,
    input  logic                       ex,
    input  logic                       undo,
    input  logic [WIDTH-1:0]           operand,
    output logic [WIDTH-1:0]           result,
    output logic                       busy,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] hist_cnt
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state;
    logic             ex_d, undo_d, sh_right, ex_go, undo_go, push, alu_ov;
    logic [SW-1:0]    sh_cnt, amt;
    logic [PW-1:0]    wp, wp_next, wp_prev;
    logic [WIDTH-1:0] sum, dif, alu;
    logic [WIDTH-1:0] hist [DEPTH];
    assign ex_go   = ex & ~ex_d;
    assign undo_go = undo & ~undo_d;
    assign push    = (state == IDLE) & ex_go;
    assign busy    = (state == SHIFT);
    assign amt     = operand[SW-1:0];
    // wp points at the next free slot; the newest entry sits just behind it
    assign wp_next = (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
    assign wp_prev = (wp == '0) ? PW'(DEPTH - 1) : wp - 1'b1;
    assign sum     = result + operand;
    assign dif     = result - operand;
    assign alu     = (func == 3'b000) ? sum :
                     (func == 3'b001) ? dif :
                     (func == 3'b010) ? result & operand :
                     (func == 3'b011) ? result | operand :
                     (func == 3'b100) ? result ^ operand :
                     (func == 3'b101) ? {{(WIDTH-1){1'b0}}, $signed(result) < $signed(operand)} :
                     result;
    assign alu_ov  = (func == 3'b000) ? (result[WIDTH-1] == operand[WIDTH-1]) && (sum[WIDTH-1] != result[WIDTH-1]) :
                     (func == 3'b001) ? (result[WIDTH-1] != operand[WIDTH-1]) && (dif[WIDTH-1] != result[WIDTH-1]) :
                     1'b0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            result   <= '0;
            overflow <= 1'b0;
            hist_cnt <= '0;
            ex_d     <= 1'b0;
            undo_d   <= 1'b0;
            wp       <= '0;
            sh_cnt   <= '0;
            sh_right <= 1'b0;
        end else begin
            ex_d   <= ex;
            undo_d <= undo;
            if (state == SHIFT) begin
                result <= sh_right ? {result[WIDTH-1], result[WIDTH-1:1]} : {result[WIDTH-2:0], 1'b0};
                sh_cnt <= sh_cnt - 1'b1;
                if (sh_cnt == SW'(1)) state <= IDLE;
            end else if (ex_go) begin
                result   <= alu;
                overflow <= alu_ov;
                wp       <= wp_next;
                if (hist_cnt != CW'(DEPTH)) hist_cnt <= hist_cnt + 1'b1;
                if (func[2:1] == 2'b11 && amt != '0) begin
                    state    <= SHIFT;
                    sh_cnt   <= amt;
                    sh_right <= func[0];
                end
            end else if (undo_go && hist_cnt != '0) begin
                result   <= hist[wp_prev];
                wp       <= wp_prev;
                hist_cnt <= hist_cnt - 1'b1;
                overflow <= 1'b0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push) hist[wp] <= result;
    end
endmodule

// File: tb/tb_calc_param.sv
// tb_calc_param: directed stimulus with a queue-based reference model compared every cycle.
module tb_calc_param;
    logic        clk = 0, rst_n = 1, ex = 0, undo = 0;
    logic [2:0]  func = 0;
    logic [15:0] operand = 0;
    logic [15:0] result;
    logic        busy, overflow;
    logic [2:0]  hist_cnt;
    int checks = 0, failures = 0;

    calc_param #(.WIDTH(16), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .func(func), .ex(ex), .undo(undo),
        .operand(operand), .result(result), .busy(busy),
        .overflow(overflow), .hist_cnt(hist_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: history as a queue, shifts as orig shifted by elapsed cycles
    logic [15:0] m_res = 0, sh_orig = 0;
    logic [15:0] hq[$];
    bit m_ov = 0, m_busy = 0, sh_right = 0, m_exd = 0, m_ud = 0, eg, ug;
    int sh_k = 0, sh_n = 0, s;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_res = 0; m_ov = 0; m_busy = 0; m_exd = 0; m_ud = 0;
            hq.delete();
        end else begin
            eg = ex && !m_exd;
            ug = undo && !m_ud;
            m_exd = ex;
            m_ud = undo;
            if (m_busy) begin
                sh_k++;
                m_res = sh_right ? 16'($signed(sh_orig) >>> sh_k) : 16'(sh_orig << sh_k);
                if (sh_k == sh_n) m_busy = 0;
            end else if (eg) begin
                hq.push_back(m_res);
                if (hq.size() > 4) void'(hq.pop_front());
                m_ov = 0;
                case (func)
                    3'd0: begin s = int'($signed(m_res)) + int'($signed(operand)); m_res = 16'(s); m_ov = s > 32767 || s < -32768; end
                    3'd1: begin s = int'($signed(m_res)) - int'($signed(operand)); m_res = 16'(s); m_ov = s > 32767 || s < -32768; end
                    3'd2: m_res = m_res & operand;
                    3'd3: m_res = m_res | operand;
                    3'd4: m_res = m_res ^ operand;
                    3'd5: m_res = ($signed(m_res) < $signed(operand)) ? 16'd1 : 16'd0;
                    default: begin
                        sh_n = int'(operand[3:0]);
                        sh_orig = m_res;
                        sh_k = 0;
                        sh_right = func[0];
                        m_busy = (sh_n != 0);
                    end
                endcase
            end else if (ug && hq.size() > 0) begin
                m_res = hq.pop_back();
                m_ov = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("result", result, m_res);
            chk("overflow", 16'(overflow), 16'(m_ov));
            chk("busy", 16'(busy), 16'(m_busy));
            chk("hist_cnt", 16'(hist_cnt), 16'(hq.size()));
        end
    end

    task automatic exec_start(input logic [2:0] f, input logic [15:0] op);
        func = f; operand = op; ex = 1;
        @(negedge clk);
        ex = 0;
    endtask

    task automatic exec(input logic [2:0] f, input logic [15:0] op);
        exec_start(f, op);
        @(negedge clk);
    endtask

    task automatic undo_pulse();
        undo = 1;
        @(negedge clk);
        undo = 0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 0;
        @(negedge clk);
        #2 rst_n = 1;
        @(negedge clk);
    endtask

    task automatic run_shift(input bit poke, output int n);
        n = 0;
        func = 0; operand = 1;
        while (busy && n < 50) begin
            n++;
            ex = poke && (n == 2);
            @(negedge clk);
        end
        ex = 0;
    endtask

    logic [15:0] uexp [5] = '{16'd4, 16'd3, 16'd2, 16'd1, 16'd1};
    logic [15:0] hexp [5] = '{16'd3, 16'd2, 16'd1, 16'd0, 16'd0};
    int n;

    initial begin
        #3 rst_n = 0;
        #1;
        chk("rst_result", result, 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_ovf", 16'(overflow), 16'h0);
        chk("rst_hist", 16'(hist_cnt), 16'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        // held ex acts once
        func = 0; operand = 16'h0005; ex = 1;
        repeat (20) @(negedge clk);
        ex = 0;
        @(negedge clk);
        chk("hold_result", result, 16'h0005);
        chk("hold_hist", 16'(hist_cnt), 16'h1);
        exec(3'd0, 16'h7FFA);
        chk("add_7fff", result, 16'h7FFF);
        exec(3'd0, 16'h0001);
        chk("add_ovf_res", result, 16'h8000);
        chk("add_ovf", 16'(overflow), 16'h1);
        exec(3'd2, 16'hFFFF);
        chk("and_res", result, 16'h8000);
        chk("and_ovf", 16'(overflow), 16'h0);
        // shift left by 4 with an ignored ex pulse while busy
        do_reset();
        exec(3'd0, 16'h0003);
        exec_start(3'd6, 16'h0004);
        run_shift(1'b1, n);
        chk("lsl_busy_cycles", 16'(n), 16'd4);
        chk("lsl_res", result, 16'h0030);
        chk("lsl_hist", 16'(hist_cnt), 16'h2);
        // history overwrite and undo underflow
        do_reset();
        repeat (5) exec(3'd0, 16'h0001);
        chk("push5_res", result, 16'h0005);
        chk("push5_hist", 16'(hist_cnt), 16'h4);
        for (int i = 0; i < 5; i++) begin
            undo_pulse();
            chk("undo_res", result, uexp[i]);
            chk("undo_hist", 16'(hist_cnt), hexp[i]);
        end
        exec(3'd0, 16'hFFFE);
        chk("neg1", result, 16'hFFFF);
        exec(3'd5, 16'h0001);
        chk("slt", result, 16'h0001);
        exec(3'd0, 16'h7FFF);
        chk("to_8000", result, 16'h8000);
        exec_start(3'd7, 16'h0003);
        run_shift(1'b0, n);
        chk("asr_busy_cycles", 16'(n), 16'd3);
        chk("asr_res", result, 16'hF000);
        exec(3'd6, 16'h0010);
        chk("amt0_res", result, 16'hF000);
        chk("amt0_busy", 16'(busy), 16'h0);
        exec(3'd0, 16'h9000);
        exec(3'd1, 16'h0001);
        chk("sub_ovf_res", result, 16'h7FFF);
        chk("sub_ovf", 16'(overflow), 16'h1);
        exec(3'd3, 16'h00F0);
        exec(3'd4, 16'hFFFF);
        chk("xor_res", result, 16'h8000);
        // reset mid-shift, then ex already high at release
        exec_start(3'd6, 16'h0007);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("abort_res", result, 16'h0);
        chk("abort_busy", 16'(busy), 16'h0);
        func = 0; operand = 16'h0003; ex = 1;
        @(negedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        ex = 0;
        @(negedge clk);
        chk("rel_ex_res", result, 16'h0003);
        chk("rel_ex_hist", 16'(hist_cnt), 16'h1);
        // ex beats undo in the same cycle
        func = 0; operand = 16'h0002; ex = 1; undo = 1;
        @(negedge clk);
        ex = 0; undo = 0;
        @(negedge clk);
        chk("exundo_res", result, 16'h0005);
        chk("exundo_hist", 16'(hist_cnt), 16'h2);
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/calc_param.md
CALC_PARAM -- requirements
Module: calc_param

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the accumulator and operand width; legal range is 4..64.
REQ-002 Parameter DEPTH, default 4, SHALL set the undo-history entry count; legal range is 1..16.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port func, input, 3 bits: operation select, sampled on the execute edge.
REQ-007 Port ex, input, 1 bit: execute button level, synchronous to clk.
REQ-008 Port undo, input, 1 bit: undo button level, synchronous to clk.
REQ-009 Port operand, input, WIDTH bits: second operand, sampled on the execute edge.
REQ-010 Port result, output, WIDTH bits: accumulator value.
REQ-011 Port busy, output, 1 bit: high while a multi-cycle shift is in progress.
REQ-012 Port overflow, output, 1 bit: signed-overflow flag of the last committed operation.
REQ-013 Port hist_cnt, output, clog2(DEPTH+1) bits: number of valid undo entries.

Function
REQ-014 The block SHALL register ex and undo into ex_d and undo_d every cycle; ex_go = ex & ~ex_d; undo_go = undo & ~undo_d.
REQ-015 A held ex or undo SHALL produce exactly one action per rising edge of the input.
REQ-016 The FSM SHALL have two states, IDLE and SHIFT; busy = (state == SHIFT).
REQ-017 In IDLE, with ex_go, a single-cycle op SHALL update result on the same clk edge that samples ex_go; latency is one edge.
REQ-018 func encoding SHALL be as follows.
- 000: add.
- 001: sub.
- 010: and.
- 011: or.
- 100: xor.
- 101: signed less-than; result is 1 if result < operand (signed), else 0.
- 110: logical shift left, multi-cycle.
- 111: arithmetic shift right, multi-cycle.
REQ-019 Add and sub SHALL be modulo 2^WIDTH; overflow is set to the two's-complement signed overflow of that operation.
REQ-020 Every committed op other than add or sub SHALL clear overflow.
REQ-021 For func 110/111, the shift amount SHALL be amt = operand[clog2(WIDTH)-1:0], latched at ex_go.
REQ-022 If amt == 0, the shift SHALL commit in one edge with result unchanged, and the FSM stays IDLE.
REQ-023 If amt > 0, the FSM SHALL enter SHIFT and shift result by 1 bit per cycle, returning to IDLE after exactly amt edges; result is final on the edge that leaves SHIFT.
REQ-024 While busy, ex_go and undo_go SHALL be ignored; ex_d and undo_d keep tracking their inputs.
REQ-025 Every committed op, including amt == 0 shifts, SHALL push the pre-op result onto the history at the same edge.
REQ-026 Push when hist_cnt == DEPTH SHALL overwrite the oldest entry (circular buffer), and hist_cnt stays at DEPTH.
REQ-027 In IDLE, undo_go with hist_cnt > 0 SHALL load result from the newest entry, decrement hist_cnt and clear overflow, in one edge.
REQ-028 undo_go with hist_cnt == 0 SHALL be a no-op.
REQ-029 If ex_go and undo_go occur in the same cycle, ex_go SHALL win and the undo is discarded.
REQ-030 The combinational path from inputs to outputs SHALL be empty; all outputs are registered.

Reset
REQ-031 rst_n low SHALL asynchronously force the following state.
- result = 0, overflow = 0, busy = 0, hist_cnt = 0.
- FSM = IDLE.
- ex_d = 0, undo_d = 0.
- History pointers = 0.
REQ-032 Reset asserted mid-shift SHALL abort the shift immediately, with no partial commit afterwards.
REQ-033 After release, ex already high SHALL count as a rising edge on the first clock.

Verification (WIDTH=16, DEPTH=4)
REQ-034 Reset, then func=000, operand=0x0005, ex held 20 cycles -> result=0x0005 after the first edge and never changes again; hist_cnt=1.
REQ-035 result=0x7FFF, add 0x0001 -> result=0x8000, overflow=1; then and 0xFFFF -> result=0x8000, overflow=0.
REQ-036 result=0x0003, func=110, operand=0x0004 -> busy high exactly 4 cycles, result=0x0030; an ex pulse during busy changes nothing.
REQ-037 Reset, five add 0x0001 ops (result=5, hist_cnt=4), then five undo pulses -> result 4,3,2,1, hist_cnt=0; the fifth undo is ignored and result stays 1.
REQ-038 result=0xFFFF, func=101, operand=0x0001 -> result=0x0001; result=0x8000, func=111, operand=0x0003 -> result=0xF000 after 3 busy cycles.
REQ-039 Start a shift with amt=7, assert rst_n low mid-shift -> result=0, busy=0 before the next edge; ex and undo in the same cycle -> the op executes and hist_cnt increments.
